err_monitor: RTL

Synthesizable error and liveness monitor that sits inside the processor top level and drives the `err` input of the testbench clock/reset generator. It merges per-unit error flags into one sticky error, records which sources fired first, and (optionally) flags a hung pipeline via a retire watchdog. It also keeps cycle and retire counters for end-of-run reporting.

---
 rtl/err_monitor.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/err_monitor.sv
// ============================================================================
// Module   : err_monitor
// Purpose  : Merges unit error flags into one sticky error, records the first
//            fault cause, and keeps RUN-state cycle and retire counters.
//            The optional retire watchdog is built when ERR_MON_WATCHDOG_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module err_monitor #(
    parameter int NSRC    = 4,
    parameter int TIMEOUT = 1000,
    parameter int CW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] err_src,
    input  logic            retire,
    input  logic            halt,
    output logic            err,
    output logic [NSRC-1:0] err_cause,
    output logic            err_wdog,
    output logic [1:0]      state,
    output logic [CW-1:0]   cycle_cnt,
    output logic [CW-1:0]   retire_cnt
);

    localparam logic [1:0] C_ST_RUN    = 2'b00;
    localparam logic [1:0] C_ST_HALTED = 2'b01;
    localparam logic [1:0] C_ST_FAULT  = 2'b10;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_err;
    logic [NSRC-1:0] r_cause;
    logic            r_wdog;
    logic [CW-1:0]   r_cyc;
    logic [CW-1:0]   r_ret;
    logic            w_err_nxt;
    logic [NSRC-1:0] w_cause_nxt;
    logic            w_wdog_nxt;
    logic [CW-1:0]   w_cyc_nxt;
    logic [CW-1:0]   w_ret_nxt;
    logic            w_expire;
    logic            w_fault;

`ifdef ERR_MON_WATCHDOG_EN
    localparam int             WDW       = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] C_WD_LAST = WDW'(TIMEOUT - 1);

    logic [WDW-1:0] r_wd_cnt;

    // Expiry is the TIMEOUT-th retire-free edge; a retire on that edge rescues it.
    assign w_expire = (r_state == C_ST_RUN) && !retire && (r_wd_cnt == C_WD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wd_cnt <= '0;
        end else if (r_state == C_ST_RUN) begin
            r_wd_cnt <= retire ? '0 : r_wd_cnt + WDW'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    assign w_fault = (|err_src) || w_expire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_RUN: begin
                if (w_fault) begin
                    w_state_nxt = C_ST_FAULT;
                end else if (halt) begin
                    w_state_nxt = C_ST_HALTED;
                end
            end
            C_ST_HALTED: w_state_nxt = C_ST_HALTED;
            C_ST_FAULT:  w_state_nxt = C_ST_FAULT;
            default:     w_state_nxt = C_ST_FAULT;
        endcase
    end

    always_comb begin
        w_err_nxt   = r_err;
        w_cause_nxt = r_cause;
        w_wdog_nxt  = r_wdog;
        w_cyc_nxt   = r_cyc;
        w_ret_nxt   = r_ret;
        case (r_state)
            C_ST_RUN: begin
                // Counters advance on the exit edge too, so a retire with halt counts.
                w_cyc_nxt = (&r_cyc) ? r_cyc : r_cyc + CW'(1);
                if (retire && !(&r_ret)) begin
                    w_ret_nxt = r_ret + CW'(1);
                end
                if (w_fault) begin
                    w_err_nxt   = 1'b1;
                    w_cause_nxt = err_src;
                    w_wdog_nxt  = w_expire;
                end
            end
            C_ST_HALTED, C_ST_FAULT: begin
            end
            default: begin
                w_err_nxt   = 1'b1;
                w_cause_nxt = '0;
                w_wdog_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err   <= 1'b0;
            r_cause <= '0;
            r_wdog  <= 1'b0;
            r_cyc   <= '0;
            r_ret   <= '0;
        end else begin
            r_err   <= w_err_nxt;
            r_cause <= w_cause_nxt;
            r_wdog  <= w_wdog_nxt;
            r_cyc   <= w_cyc_nxt;
            r_ret   <= w_ret_nxt;
        end
    end

    assign err        = r_err;
    assign err_cause  = r_cause;
    assign err_wdog   = r_wdog;
    assign state      = r_state;
    assign cycle_cnt  = r_cyc;
    assign retire_cnt = r_ret;

endmodule

`default_nettype wire
